// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state and opcode definitions for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - combinational conditional two's-complement negate
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    localparam logic [W-1:0] ONE = 1;

    // Pass through, or invert-and-increment when neg is set
    always_comb begin
        result = neg ? (~value + ONE) : value;
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiplier and restoring divider
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = 1;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, b_r, m_r, p_hi, p_lo, cnt;
    logic             op_r, sgn_r, neg_q, neg_r;

    logic             sa, sb, b_zero, accept;
    logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;

    // Operand signs only count when signed mode is active for this operation
    always_comb begin
        sa     = sgn_r & a_r[WIDTH-1];
        sb     = sgn_r & b_r[WIDTH-1];
        b_zero = (b_r == '0);
        accept = start && (state == S_IDLE || state == S_DONE);
    end

    muldiv_negate #(.W(WIDTH)) u_neg_a (.value(a_r), .neg(sa), .result(a_abs));
    muldiv_negate #(.W(WIDTH)) u_neg_b (.value(b_r), .neg(sb), .result(b_abs));
    muldiv_negate #(.W(2*WIDTH)) u_neg_prod (.value({p_hi, p_lo}), .neg(neg_q), .result(prod_fix));
    muldiv_negate #(.W(WIDTH)) u_neg_q (.value(p_lo), .neg(neg_q), .result(q_fix));
    muldiv_negate #(.W(WIDTH)) u_neg_r (.value(p_hi), .neg(neg_r), .result(r_fix));

    // One iteration step: shift-add for multiply, trial subtract for divide
    always_comb begin
        mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
        div_shift = {p_hi, p_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_r};
    end

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_PREP;
            end
            S_PREP: begin
                busy = 1'b1;
                if (op_r == OP_DIV && b_zero) state_nxt = S_DONE;
                else                          state_nxt = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_PREP : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_r         <= '0;
            b_r         <= '0;
            m_r         <= '0;
            p_hi        <= '0;
            p_lo        <= '0;
            cnt         <= '0;
            op_r        <= 1'b0;
            sgn_r       <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_by_zero <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
        end else begin
            if (accept) begin
                a_r         <= a;
                b_r         <= b;
                op_r        <= op;
                sgn_r       <= (SIGNED_EN != 0) && is_signed;
                div_by_zero <= 1'b0;
            end
            case (state)
                S_PREP: begin
                    cnt   <= '0;
                    p_hi  <= '0;
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    if (op_r == OP_DIV) begin
                        p_lo <= a_abs;
                        m_r  <= b_abs;
                        if (b_zero) begin
                            div_by_zero <= 1'b1;
                            result_lo   <= '1;
                            result_hi   <= a_r;
                        end
                    end else begin
                        p_lo <= b_abs;
                        m_r  <= a_abs;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_ONE;
                    if (op_r == OP_MUL) begin
                        p_hi <= mul_sum[WIDTH:1];
                        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    end else begin
                        p_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end
                end
                S_FIX: begin
                    if (op_r == OP_MUL) begin
                        {result_hi, result_lo} <= prod_fix;
                    end else begin
                        result_lo <= q_fix;
                        result_hi <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] result_hi, result_lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32), .SIGNED_EN(1)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; op = o; is_signed = s; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        nbusy = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        total += 5;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        if (result_hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", result_hi); end
        if (result_lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", result_lo); end
        clr = 1'b1;
    endtask

    task automatic test_mul;
        int lat, nb;
        run_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFD, lat, nb);
        total += 5;
        if (lat !== 35) begin bad++; $display("FAIL smul_lat got=%0d exp=35", lat); end
        if (nb !== 34) begin bad++; $display("FAIL smul_busy_cycles got=%0d exp=34", nb); end
        if (busy !== 1'b0) begin bad++; $display("FAIL smul_busy_in_done got=%b exp=0", busy); end
        if (result_hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL smul_hi got=%h exp=FFFFFFFF", result_hi); end
        if (result_lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL smul_lo got=%h exp=FFFFFFEB", result_lo); end

        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb);
        total += 2;
        if (result_hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL umul_max_hi got=%h exp=FFFFFFFE", result_hi); end
        if (result_lo !== 32'h00000001) begin bad++; $display("FAIL umul_max_lo got=%h exp=00000001", result_lo); end

        run_op(1'b0, 1'b1, 32'h80000000, 32'h80000000, lat, nb);
        total += 2;
        if (result_hi !== 32'h40000000) begin bad++; $display("FAIL smul_minmin_hi got=%h exp=40000000", result_hi); end
        if (result_lo !== 32'h00000000) begin bad++; $display("FAIL smul_minmin_lo got=%h exp=00000000", result_lo); end
    endtask

    task automatic test_div;
        int lat, nb;
        run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, nb);
        total += 3;
        if (lat !== 35) begin bad++; $display("FAIL udiv_lat got=%0d exp=35", lat); end
        if (result_lo !== 32'h0000000E) begin bad++; $display("FAIL udiv_q got=%h exp=0000000E", result_lo); end
        if (result_hi !== 32'h00000002) begin bad++; $display("FAIL udiv_r got=%h exp=00000002", result_hi); end

        run_op(1'b1, 1'b1, 32'hFFFFFF9C, 32'd7, lat, nb);
        total += 2;
        if (result_lo !== 32'hFFFFFFF2) begin bad++; $display("FAIL sdiv_negnum_q got=%h exp=FFFFFFF2", result_lo); end
        if (result_hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL sdiv_negnum_r got=%h exp=FFFFFFFE", result_hi); end

        run_op(1'b1, 1'b1, 32'd100, 32'hFFFFFFF9, lat, nb);
        total += 2;
        if (result_lo !== 32'hFFFFFFF2) begin bad++; $display("FAIL sdiv_negden_q got=%h exp=FFFFFFF2", result_lo); end
        if (result_hi !== 32'h00000002) begin bad++; $display("FAIL sdiv_negden_r got=%h exp=00000002", result_hi); end

        run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, nb);
        total += 3;
        if (result_lo !== 32'h80000000) begin bad++; $display("FAIL sdiv_ovf_q got=%h exp=80000000", result_lo); end
        if (result_hi !== 32'h00000000) begin bad++; $display("FAIL sdiv_ovf_r got=%h exp=00000000", result_hi); end
        if (div_by_zero !== 1'b0) begin bad++; $display("FAIL sdiv_ovf_flag got=%b exp=0", div_by_zero); end

        run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'd10, lat, nb);
        total += 2;
        if (result_lo !== 32'h19999999) begin bad++; $display("FAIL udiv_max_q got=%h exp=19999999", result_lo); end
        if (result_hi !== 32'h00000005) begin bad++; $display("FAIL udiv_max_r got=%h exp=00000005", result_hi); end
    endtask

    task automatic test_div_by_zero;
        int lat, nb;
        int seen;
        run_op(1'b1, 1'b0, 32'd5, 32'd0, lat, nb);
        total += 4;
        if (lat !== 2) begin bad++; $display("FAIL dbz_lat got=%0d exp=2", lat); end
        if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        if (result_lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dbz_lo got=%h exp=FFFFFFFF", result_lo); end
        if (result_hi !== 32'h00000005) begin bad++; $display("FAIL dbz_hi got=%h exp=00000005", result_hi); end

        @(negedge clk);
        total += 1;
        if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_held got=%b exp=1", div_by_zero); end

        start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        total += 1;
        if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%b exp=0", div_by_zero); end
        seen = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin seen = c; break; end
        end
        total += 2;
        if (seen !== 35) begin bad++; $display("FAIL dbz_next_lat got=%0d exp=35", seen); end
        if (result_lo !== 32'd15) begin bad++; $display("FAIL dbz_next_lo got=%h exp=0000000F", result_lo); end
    endtask

    task automatic test_reset_abort;
        int lat, nb, stray;
        @(negedge clk);
        start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'd9; b = 32'd11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        clr = 1'b0;
        #1;
        total += 4;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
        if (result_hi !== 32'h0) begin bad++; $display("FAIL abort_hi got=%h exp=0", result_hi); end
        if (result_lo !== 32'h0) begin bad++; $display("FAIL abort_lo got=%h exp=0", result_lo); end
        repeat (3) @(negedge clk);
        clr = 1'b1;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        total += 1;
        if (stray !== 0) begin bad++; $display("FAIL abort_stray got=%0d exp=0", stray); end
        run_op(1'b0, 1'b0, 32'd9, 32'd11, lat, nb);
        total += 2;
        if (lat !== 35) begin bad++; $display("FAIL abort_restart_lat got=%0d exp=35", lat); end
        if (result_lo !== 32'd99) begin bad++; $display("FAIL abort_restart_lo got=%h exp=00000063", result_lo); end
    endtask

    task automatic test_back_to_back;
        int first, second, ndone;
        @(negedge clk);
        start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'd3; b = 32'd4;
        @(posedge clk);
        first = -1; second = -1; ndone = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) first = c;
                else begin
                    second = c;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        total += 4;
        if (first !== 35) begin bad++; $display("FAIL b2b_first got=%0d exp=35", first); end
        if (second !== 70) begin bad++; $display("FAIL b2b_second got=%0d exp=70", second); end
        if (result_lo !== 32'd12) begin bad++; $display("FAIL b2b_lo got=%h exp=0000000C", result_lo); end
        if (result_hi !== 32'd0) begin bad++; $display("FAIL b2b_hi got=%h exp=00000000", result_hi); end
        @(negedge clk);
        total += 1;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
